// File: rtl/wb_intercon_rr.sv
// Round-robin Wishbone interconnect: NUM_MASTERS masters share one bus onto NUM_SLAVES slaves.
// Define WB_INTERCON_TIMEOUT_EN to build in the bus watchdog; default build has none.
module wb_intercon_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES = 6,
    parameter int S_ADDR_W = 3,
    parameter logic [NUM_SLAVES*S_ADDR_W-1:0] S_ADDR =
        {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS*32-1:0] m_adr_i,
    input  logic [NUM_MASTERS*32-1:0] m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    output logic [31:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [NUM_SLAVES-1:0]     s_cyc_o,
    output logic [NUM_SLAVES-1:0]     s_stb_o,
    input  logic [NUM_SLAVES*32-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]     s_ack_i
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q;
    logic [MW-1:0]   owner_q, last_owner_q, nxt_owner;
    logic            any_req;
    logic            busy, own_cyc, own_stb;
    logic [31:0]     own_adr;
    logic [SW-1:0]   sel;
    logic            hit;
    logic            ack_raw, err_out, tmo_hit;
    logic            err_q, err_d;

    assign busy = (state_q == BUSY);

    // Round-robin pick: smallest offset after last_owner wins, so iterate offsets downward.
    always_comb begin
        nxt_owner = '0;
        any_req   = 1'b0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (m_cyc_i[(int'(last_owner_q) + i) % NUM_MASTERS]) begin
                nxt_owner = MW'((int'(last_owner_q) + i) % NUM_MASTERS);
                any_req   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= MW'(NUM_MASTERS - 1);
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    owner_q <= nxt_owner;
                    state_q <= BUSY;
                end
                BUSY: if (!m_cyc_i[owner_q]) begin
                    last_owner_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Owner mux and address decode; descending scan makes the lowest duplicate tag win.
    always_comb begin
        own_cyc = busy & m_cyc_i[owner_q];
        own_stb = own_cyc & m_stb_i[owner_q];
        own_adr = busy ? m_adr_i[32*int'(owner_q) +: 32] : '0;
        s_adr_o = own_adr;
        s_dat_o = busy ? m_dat_i[32*int'(owner_q) +: 32] : '0;
        s_sel_o = busy ? m_sel_i[4*int'(owner_q) +: 4] : '0;
        s_we_o  = busy & m_we_i[owner_q];
        sel     = '0;
        hit     = 1'b0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (own_adr[31:32-S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
                sel = SW'(k);
                hit = busy;
            end
        end
    end

`ifdef WB_INTERCON_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;

    assign tmo_hit = own_stb & (wdog_q == 16'(TIMEOUT_CYCLES));

    always_comb begin
        wdog_d = wdog_q + 16'd1;
        if (!own_stb || ack_raw || err_out) wdog_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wdog_q <= '0;
        else      wdog_q <= wdog_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Ack always beats err, which also keeps the two mutually exclusive.
    always_comb begin
        ack_raw = hit & own_cyc & s_ack_i[sel];
        err_out = busy & (err_q | tmo_hit) & ~ack_raw;
        err_d   = own_stb & ~hit & ~err_q;
        m_dat_o = hit ? s_dat_i[32*int'(sel) +: 32] : '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_ack_o[owner_q] = ack_raw;
        m_err_o[owner_q] = err_out;
        s_cyc_o = '0;
        s_stb_o = '0;
        s_cyc_o[sel] = hit & own_cyc;
        s_stb_o[sel] = hit & own_stb & ~tmo_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

endmodule

// File: tb/tb_wb_intercon_rr.sv
// Directed bench for wb_intercon_rr: decode, round-robin, decode-miss err, watchdog, async reset.
module tb_wb_intercon_rr;

    localparam int NM = 2;
    localparam int NS = 6;

    logic            clk, rst;
    logic [NM*32-1:0] m_adr, m_dat;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_we, m_cyc, m_stb;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [NS*32-1:0] s_dat;
    logic [NS-1:0]    s_ack;

    int n_chk = 0;
    int n_fail = 0;

    // Slave 1 tag is 3'b001 so that 0x2000_0004 decodes to slave 1 and 0xE000_0000 matches nothing.
    wb_intercon_rr #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .S_ADDR_W(3),
        .S_ADDR({3'b110, 3'b101, 3'b100, 3'b011, 3'b001, 3'b000}),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic err_seen;
        rst   = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_dat = '0; s_ack = '0;
        #1;
        chk("reset_s_cyc", 64'(s_cyc_o), 64'h0);
        chk("reset_s_stb", 64'(s_stb_o), 64'h0);
        chk("reset_ack", 64'(m_ack_o), 64'h0);
        chk("reset_err", 64'(m_err_o), 64'h0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Master 0 read from slave 1, slave answers immediately.
        m_adr[31:0] = 32'h2000_0004; m_sel[3:0] = 4'hF;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        s_dat[63:32] = 32'hDEAD_BEEF; s_ack[1] = 1'b1;
        #1;
        chk("rd_pre_grant_cyc", 64'(s_cyc_o), 64'h0);
        tick();
        chk("rd_s_cyc", 64'(s_cyc_o), 64'b000010);
        chk("rd_s_adr", 64'(s_adr_o), 64'h2000_0004);
        chk("rd_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
        chk("rd_ack", 64'(m_ack_o), 64'b01);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();

        // Master 1 hits no tag: one err pulse a cycle after its strobe reaches the bus.
        m_adr[63:32] = 32'hE000_0000;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        chk("miss_err_lat", 64'(m_err_o), 64'h0);
        chk("miss_s_cyc0", 64'(s_cyc_o), 64'h0);
        tick();
        chk("miss_err", 64'(m_err_o), 64'b10);
        chk("miss_s_cyc1", 64'(s_cyc_o), 64'h0);
        chk("miss_ack", 64'(m_ack_o), 64'h0);
        tick();
        chk("miss_err_once", 64'(m_err_o), 64'h0);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();

        // Both masters keep requesting; each drops cyc on its ack and re-requests in the idle cycle.
        m_adr[31:0] = 32'h2000_0010; m_adr[63:32] = 32'h2000_0020;
        m_dat[63:32] = 32'h1234_5678; m_we[1] = 1'b1;
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_grant%0d", i), 64'(m_ack_o), 64'(2'b01 << (i % 2)));
            if (i == 1) chk("rr_wdat", 64'(s_dat_o), 64'h1234_5678);
            m_cyc[i % 2] = 1'b0; m_stb[i % 2] = 1'b0;
            tick();
            chk($sformatf("rr_idle%0d", i), 64'(m_ack_o), 64'h0);
            if (i < 4) begin
                m_cyc[i % 2] = 1'b1; m_stb[i % 2] = 1'b1;
            end
        end
        m_we = '0;
        tick();

        // Master 0 to slave 5, which never acks.
        m_adr[31:0] = 32'hC000_0000;
        s_ack = '0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        chk("wd_s_stb_start", 64'(s_stb_o), 64'b100000);
        err_seen = 1'b0;
`ifdef WB_INTERCON_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            err_seen |= |m_err_o;
            tick();
        end
        chk("wd_no_early_err", 64'(err_seen), 64'h0);
        chk("wd_err", 64'(m_err_o), 64'b01);
        chk("wd_stb_mask", 64'(s_stb_o), 64'h0);
        chk("wd_cyc_kept", 64'(s_cyc_o), 64'b100000);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        for (int c = 0; c < 16; c++) tick();
        s_ack[5] = 1'b1;
        #1;
        chk("wd_ack_wins_ack", 64'(m_ack_o), 64'b01);
        chk("wd_ack_wins_err", 64'(m_err_o), 64'h0);
`else
        for (int c = 0; c < 40; c++) begin
            err_seen |= |m_err_o;
            tick();
        end
        chk("nowd_no_err", 64'(err_seen), 64'h0);
        chk("nowd_still_stb", 64'(s_stb_o), 64'b100000);
`endif
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = '0;
        tick();

        // Reset during an access to slave 3 aborts it; master 0 must win after release.
        m_adr[31:0] = 32'h8000_0000;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        chk("rst_pre_s_cyc", 64'(s_cyc_o), 64'b001000);
        s_ack[3] = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
        chk("rst_s_stb", 64'(s_stb_o), 64'h0);
        chk("rst_ack", 64'(m_ack_o), 64'h0);
        chk("rst_err", 64'(m_err_o), 64'h0);
        m_adr[31:0] = 32'h2000_0000; m_adr[63:32] = 32'h2000_0000;
        s_ack = '0; s_ack[1] = 1'b1;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_first_grant", 64'(m_ack_o), 64'b01);
        m_cyc = '0; m_stb = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
